// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I 5-stage pipeline hazard, forwarding and debug-halt control
//
// Purpose:
//   Drives the stall/flush controls of the pipeline register bank, selects
//   EX-stage operand forwarding, and runs the debug halt handshake that
//   drains EX/MEM/WB before acknowledging.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   Defined   -> STALL_CNT / FLUSH_CNT performance counters are built.
//   Undefined -> no counter registers; STALL_CNT / FLUSH_CNT tie to 0.
//
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   RS1_ID/RS2_ID       source registers of the instruction in ID
//   USE_RS1_ID/RS2_ID   ID instruction actually reads rs1/rs2
//   RS1_DE/RS2_DE/RD_DE register fields of the instruction in EX
//   RegWrite_DE         EX instruction writes rd
//   MemRead_DE          non-zero when the EX instruction is a load
//   BR_TAKEN_E          branch/jump in EX resolved taken
//   RD_EM/RegWrite_EM   destination/write-enable of the MEM instruction
//   MemtoReg_EM         MEM writeback source (00 ALU, 01 load, 10 PC+4)
//   RD_MW/RegWrite_MW   destination/write-enable of the WB instruction
//   HALT_REQ            debug halt request (level)
//   stall_PC/stall_FD   hold PC / IF-ID register
//   stall_DE            hold ID-EX register (never used, tied 0)
//   flush_FD/flush_DE   zero IF-ID / ID-EX register
//   PC_SEL              PC loads the EX branch target
//   FWD_A/FWD_B         EX operand source: 00 RF/DE, 01 EM, 10 MW
//   HALT_ACK            pipeline halted and empty
//   STALL_CNT/FLUSH_CNT stall-cycle and branch-flush counts

module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             USE_RS1_ID,
  input  logic             USE_RS2_ID,
  input  logic [4:0]       RS1_DE,
  input  logic [4:0]       RS2_DE,
  input  logic [4:0]       RD_DE,
  input  logic             RegWrite_DE,
  input  logic [1:0]       MemRead_DE,
  input  logic             BR_TAKEN_E,
  input  logic [4:0]       RD_EM,
  input  logic             RegWrite_EM,
  input  logic [1:0]       MemtoReg_EM,
  input  logic [4:0]       RD_MW,
  input  logic             RegWrite_MW,
  input  logic             HALT_REQ,
  output logic             stall_PC,
  output logic             PC_SEL,
  output logic             stall_FD,
  output logic             stall_DE,
  output logic             flush_FD,
  output logic             flush_DE,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic             HALT_ACK,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic load_use;
  logic bubble;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic. Dropping HALT_REQ aborts a drain immediately,
  // even on the cycle that would otherwise complete it.
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (HALT_REQ) begin
          state_d = ST_DRAIN;
          cnt_d   = 3'd0;
        end
      end
      ST_DRAIN: begin
        if (!HALT_REQ) begin
          state_d = ST_RUN;
          cnt_d   = 3'd0;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = ST_HALTED;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_HALTED: begin
        if (!HALT_REQ) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Hazard detection and control outputs
  // ------------------------------------------------------------------
  always_comb begin
    load_use = (MemRead_DE != 2'b00) && RegWrite_DE && (RD_DE != 5'd0) &&
               ((USE_RS1_ID && (RS1_ID == RD_DE)) ||
                (USE_RS2_ID && (RS2_ID == RD_DE)));
    bubble   = (state_q != ST_RUN);
  end

  always_comb begin
    stall_PC = 1'b0;
    PC_SEL   = 1'b0;
    stall_FD = 1'b0;
    stall_DE = 1'b0;
    flush_FD = 1'b0;
    flush_DE = 1'b0;
    FWD_A    = 2'b00;
    FWD_B    = 2'b00;
    HALT_ACK = 1'b0;
    if (!RST) begin
      // A taken branch wins over everything: the ID instruction is on the
      // wrong path, so any load-use stall for it is moot.
      if (BR_TAKEN_E) begin
        PC_SEL   = 1'b1;
        flush_FD = 1'b1;
        flush_DE = 1'b1;
      end else if (bubble || load_use) begin
        stall_PC = 1'b1;
        stall_FD = 1'b1;
        flush_DE = 1'b1;
      end

      HALT_ACK = (state_q == ST_HALTED);

      // Loads in MEM have no data yet, so only non-load EM results forward.
      if (RegWrite_EM && (RD_EM != 5'd0) && (RD_EM == RS1_DE) &&
          (MemtoReg_EM != 2'b01)) begin
        FWD_A = 2'b01;
      end else if (RegWrite_MW && (RD_MW != 5'd0) && (RD_MW == RS1_DE)) begin
        FWD_A = 2'b10;
      end

      if (RegWrite_EM && (RD_EM != 5'd0) && (RD_EM == RS2_DE) &&
          (MemtoReg_EM != 2'b01)) begin
        FWD_B = 2'b01;
      end else if (RegWrite_MW && (RD_MW != 5'd0) && (RD_MW == RS2_DE)) begin
        FWD_B = 2'b10;
      end
    end
  end

  // ------------------------------------------------------------------
  // Performance counters
  // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_FD) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (PC_SEL) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`else
  assign STALL_CNT = '0;
  assign FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl

module tb_hazard_ctrl;

  localparam int DC   = 3;
  localparam int CW   = 4;
  localparam int CMAX = 1 << CW;

  logic          CLK;
  logic          RST;
  logic [4:0]    RS1_ID, RS2_ID;
  logic          USE_RS1_ID, USE_RS2_ID;
  logic [4:0]    RS1_DE, RS2_DE, RD_DE;
  logic          RegWrite_DE;
  logic [1:0]    MemRead_DE;
  logic          BR_TAKEN_E;
  logic [4:0]    RD_EM;
  logic          RegWrite_EM;
  logic [1:0]    MemtoReg_EM;
  logic [4:0]    RD_MW;
  logic          RegWrite_MW;
  logic          HALT_REQ;
  logic          stall_PC, PC_SEL, stall_FD, stall_DE, flush_FD, flush_DE;
  logic [1:0]    FWD_A, FWD_B;
  logic          HALT_ACK;
  logic [CW-1:0] STALL_CNT, FLUSH_CNT;

  hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
    .USE_RS1_ID(USE_RS1_ID), .USE_RS2_ID(USE_RS2_ID),
    .RS1_DE(RS1_DE), .RS2_DE(RS2_DE), .RD_DE(RD_DE),
    .RegWrite_DE(RegWrite_DE), .MemRead_DE(MemRead_DE),
    .BR_TAKEN_E(BR_TAKEN_E),
    .RD_EM(RD_EM), .RegWrite_EM(RegWrite_EM), .MemtoReg_EM(MemtoReg_EM),
    .RD_MW(RD_MW), .RegWrite_MW(RegWrite_MW),
    .HALT_REQ(HALT_REQ),
    .stall_PC(stall_PC), .PC_SEL(PC_SEL), .stall_FD(stall_FD),
    .stall_DE(stall_DE), .flush_FD(flush_FD), .flush_DE(flush_DE),
    .FWD_A(FWD_A), .FWD_B(FWD_B), .HALT_ACK(HALT_ACK),
    .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: halt progress is "cycles spent since the halt began"
  // (-1 = not halting); acknowledged once DC bubble cycles have elapsed.
  int halt_age = -1;
  int m_stall  = 0;
  int m_flush  = 0;

  logic       e_spc, e_psel, e_sfd, e_ffd, e_fde, e_ack;
  logic [1:0] e_fa, e_fb;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (RegWrite_EM && RD_EM != 0 && RD_EM == src && MemtoReg_EM != 2'b01) return 2'b01;
    if (RegWrite_MW && RD_MW != 0 && RD_MW == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_eval();
    logic lu;
    lu = (MemRead_DE != 0) && RegWrite_DE && (RD_DE != 0) &&
         ((USE_RS1_ID && RS1_ID == RD_DE) || (USE_RS2_ID && RS2_ID == RD_DE));
    {e_spc, e_psel, e_sfd, e_ffd, e_fde, e_ack} = '0;
    e_fa = 2'b00;
    e_fb = 2'b00;
    if (!RST) begin
      if (BR_TAKEN_E) begin
        e_psel = 1; e_ffd = 1; e_fde = 1;
      end else if (halt_age >= 0 || lu) begin
        e_spc = 1; e_sfd = 1; e_fde = 1;
      end
      e_ack = (halt_age >= DC);
      e_fa  = fwd_sel(RS1_DE);
      e_fb  = fwd_sel(RS2_DE);
    end
  endtask

  task automatic model_step();
    if (RST) begin
      halt_age = -1;
      m_stall  = 0;
      m_flush  = 0;
    end else begin
      m_stall = (m_stall + int'(e_sfd)) % CMAX;
      m_flush = (m_flush + int'(e_psel)) % CMAX;
      if (!HALT_REQ)          halt_age = -1;
      else if (halt_age < DC) halt_age = halt_age + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(negedge CLK);
    model_eval();
    chk("stall_PC", 32'(stall_PC), 32'(e_spc));
    chk("PC_SEL",   32'(PC_SEL),   32'(e_psel));
    chk("stall_FD", 32'(stall_FD), 32'(e_sfd));
    chk("stall_DE", 32'(stall_DE), 32'd0);
    chk("flush_FD", 32'(flush_FD), 32'(e_ffd));
    chk("flush_DE", 32'(flush_DE), 32'(e_fde));
    chk("FWD_A",    32'(FWD_A),    32'(e_fa));
    chk("FWD_B",    32'(FWD_B),    32'(e_fb));
    chk("HALT_ACK", 32'(HALT_ACK), 32'(e_ack));
`ifdef HAZARD_PERF_CNT_EN
    chk("STALL_CNT", 32'(STALL_CNT), 32'(m_stall));
    chk("FLUSH_CNT", 32'(FLUSH_CNT), 32'(m_flush));
`else
    chk("STALL_CNT", 32'(STALL_CNT), 32'd0);
    chk("FLUSH_CNT", 32'(FLUSH_CNT), 32'd0);
`endif
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle();
    RST = 0; RS1_ID = 0; RS2_ID = 0; USE_RS1_ID = 0; USE_RS2_ID = 0;
    RS1_DE = 0; RS2_DE = 0; RD_DE = 0; RegWrite_DE = 0; MemRead_DE = 0;
    BR_TAKEN_E = 0; RD_EM = 0; RegWrite_EM = 0; MemtoReg_EM = 0;
    RD_MW = 0; RegWrite_MW = 0; HALT_REQ = 0;
  endtask

  task automatic set_load_use();
    MemRead_DE = 2'b01; RegWrite_DE = 1; RD_DE = 5; RS1_ID = 5; USE_RS1_ID = 1;
  endtask

  initial begin
    idle();
    RST = 1;
    cycle();
    cycle();
    RST = 0;
    cycle();

    // Load-use: one bubble, then MW forwarding of the load result
    set_load_use();
    cycle();
    idle();
    RS1_DE = 5; RD_MW = 5; RegWrite_MW = 1; RD_EM = 7; RegWrite_EM = 1;
    cycle();
    chk("lu_fwd_a_mw", 32'(FWD_A), 32'd2);

    // EM beats MW; x0 never forwards
    idle();
    RD_EM = 3; RD_MW = 3; RegWrite_EM = 1; RegWrite_MW = 1; RS2_DE = 3;
    cycle();
    RD_EM = 0; RS1_DE = 0;
    cycle();

    // Load in EM must not forward from EM
    idle();
    RD_EM = 9; RegWrite_EM = 1; MemtoReg_EM = 2'b01; RS1_DE = 9; RS2_DE = 9;
    RD_MW = 9; RegWrite_MW = 1;
    cycle();

    // Taken branch overrides load-use
    idle();
    set_load_use();
    BR_TAKEN_E = 1;
    cycle();
    idle();
    cycle();

    // Full halt: held, acknowledged, released
    HALT_REQ = 1;
    for (int i = 0; i < 7; i++) begin
      BR_TAKEN_E = (i == 2);
      cycle();
    end
    BR_TAKEN_E = 0;
    chk("halt_ack_held", 32'(HALT_ACK), 32'd1);
    HALT_REQ = 0;
    cycle();
    cycle();

    // Aborted drain: ack never asserts
    HALT_REQ = 1;
    cycle();
    cycle();
    HALT_REQ = 0;
    for (int i = 0; i < 5; i++) cycle();

    // Reset pulsed while halted
    HALT_REQ = 1;
    for (int i = 0; i < 6; i++) cycle();
    RST = 1;
    cycle();
    RST = 0; HALT_REQ = 0;
    cycle();

    // 17 load-use stalls wrap a 4-bit counter to 1
    RST = 1;
    cycle();
    idle();
    set_load_use();
    for (int i = 0; i < 17; i++) cycle();
    idle();
    @(negedge CLK);
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_wrap", 32'(STALL_CNT), 32'd1);
`else
    chk("stall_wrap", 32'(STALL_CNT), 32'd0);
`endif
    @(posedge CLK);
    model_step();
    #1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      RST         = ($urandom_range(0, 99) == 0);
      RS1_ID      = 5'($urandom_range(0, 3));
      RS2_ID      = 5'($urandom_range(0, 3));
      USE_RS1_ID  = 1'($urandom_range(0, 1));
      USE_RS2_ID  = 1'($urandom_range(0, 1));
      RS1_DE      = 5'($urandom_range(0, 3));
      RS2_DE      = 5'($urandom_range(0, 3));
      RD_DE       = 5'($urandom_range(0, 3));
      RegWrite_DE = 1'($urandom_range(0, 1));
      MemRead_DE  = 2'($urandom_range(0, 3));
      BR_TAKEN_E  = ($urandom_range(0, 7) == 0);
      RD_EM       = 5'($urandom_range(0, 3));
      RegWrite_EM = 1'($urandom_range(0, 1));
      MemtoReg_EM = 2'($urandom_range(0, 2));
      RD_MW       = 5'($urandom_range(0, 3));
      RegWrite_MW = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) HALT_REQ = ~HALT_REQ;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline control unit that drives the stall/flush inputs of the 5-stage RV32I pipeline register bank and selects EX-stage operand forwarding. Detects load-use hazards and taken branches/jumps resolved in EX. Implements a debug halt handshake that drains the pipeline before acknowledging. Sits beside the pipeline register bank, consuming decoded ID fields and the DE/EM/MW register outputs.

Parameters:
DRAIN_CYCLES, 3, bubble cycles inserted after a halt request before HALT_ACK (clears EX, MEM, WB); legal range 1-7
CNT_W, 32, width of the performance counters (optional feature)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
RS1_ID  in  5  rs1 field of IDATA_FD
RS2_ID  in  5  rs2 field of IDATA_FD
USE_RS1_ID  in  1  ID instruction reads rs1
USE_RS2_ID  in  1  ID instruction reads rs2
RS1_DE  in  5  rs1 of the instruction in EX
RS2_DE  in  5  rs2 of the instruction in EX
RD_DE  in  5  destination register in EX
RegWrite_DE  in  1  EX instruction writes rd
MemRead_DE  in  2  non-zero = EX instruction is a load
BR_TAKEN_E  in  1  branch/jump in EX resolved taken
RD_EM  in  5  destination register in MEM
RegWrite_EM  in  1  MEM instruction writes rd
MemtoReg_EM  in  2  00 ALU, 01 load data, 10 PC+4
RD_MW  in  5  destination register in WB
RegWrite_MW  in  1  WB instruction writes rd
HALT_REQ  in  1  debug halt request, level
stall_PC  out  1  hold PC
PC_SEL  out  1  1 = PC loads EX branch target (priority over stall_PC)
stall_FD  out  1  hold IF/ID register
stall_DE  out  1  hold ID/EX register (always 0 in this revision)
flush_FD  out  1  zero IF/ID register (NOP)
flush_DE  out  1  zero ID/EX register (bubble)
FWD_A  out  2  EX rs1 source: 00 RF/DE, 01 EM, 10 MW
FWD_B  out  2  EX rs2 source, same encoding
HALT_ACK  out  1  pipeline halted and empty
STALL_CNT  out  CNT_W  stall cycle count (optional feature)
FLUSH_CNT  out  CNT_W  branch flush count (optional feature)

Behaviour:
- All control outputs are combinational from the FSM state and current inputs, so stalls and flushes take effect at the same edge. While RST=1, every output is 0; on the following edge the state is RUN and the drain counter is 0.
- load_use = MemRead_DE!=0 & RegWrite_DE & RD_DE!=0 & ((USE_RS1_ID & RS1_ID==RD_DE) | (USE_RS2_ID & RS2_ID==RD_DE)).
- Priority: BR_TAKEN_E > halt bubbles > load_use.
- Taken branch: PC_SEL=1, flush_FD=1, flush_DE=1, stall_PC=stall_FD=0. Applies in every state; a pending load_use is discarded (wrong-path instruction).
- load_use in RUN: stall_PC=1, stall_FD=1, flush_DE=1, giving exactly one bubble. On the next cycle the load is in MEM and load_use is false.
- Forwarding (rs1 shown; rs2 identical):
  - FWD_A=01 when RegWrite_EM, RD_EM!=0, RD_EM==RS1_DE and MemtoReg_EM!=01.
  - Otherwise FWD_A=10 when RegWrite_MW, RD_MW!=0 and RD_MW==RS1_DE.
  - Otherwise FWD_A=00.
  - EM has priority over MW. x0 never forwards.
- FSM, 3 states:
  - RUN: HALT_REQ=1 -> DRAIN with cnt=0.
  - DRAIN: stall_PC=stall_FD=flush_DE=1. cnt increments each cycle. cnt==DRAIN_CYCLES-1 -> HALTED. HALT_REQ=0 -> RUN next edge (abort).
  - HALTED: same bubble outputs, HALT_ACK=1. HALT_REQ=0 -> RUN.
- A taken branch during DRAIN (from the instruction in EX at entry) still redirects the PC and flushes FD. The drain count continues.
- RST in any state returns to RUN, cnt=0, counters=0.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: STALL_CNT increments on each cycle with stall_FD=1 (load-use or halt); FLUSH_CNT increments on each cycle with PC_SEL=1. Both wrap modulo 2^CNT_W and clear on RST.
- Undefined: no counter registers are built, and STALL_CNT and FLUSH_CNT are constant 0.

Test Plan:
- lw x5 in EX (MemRead_DE=01, RD_DE=5), ID add using RS1_ID=5 -> one cycle of stall_PC=stall_FD=flush_DE=1, then 0. Next cycle, with RD_MW=5 and RegWrite_MW=1 at RS1_DE=5, FWD_A=10.
- RD_EM=RD_MW=3, both RegWrite=1, MemtoReg_EM=00, RS2_DE=3 -> FWD_B=01. With RD_EM=0 and RS1_DE=0 -> FWD_A=00.
- BR_TAKEN_E=1 while load_use is true -> PC_SEL=1, flush_FD=flush_DE=1, stall_PC=0. FLUSH_CNT increments by 1 when HAZARD_PERF_CNT_EN is defined.
- HALT_REQ=1 held, DRAIN_CYCLES=3 -> 3 bubble cycles, then HALT_ACK=1 on the 4th cycle. Deassert HALT_REQ -> HALT_ACK=0 and all stalls 0 on the next cycle.
- HALT_REQ dropped after 1 DRAIN cycle -> RUN, HALT_ACK never asserts. RST pulsed in HALTED -> outputs 0 and state RUN.
- With HAZARD_PERF_CNT_EN and CNT_W=4: 17 stall cycles -> STALL_CNT=1 (wrap).
